mem_port_arbiter: RTL and testbench

Arbitrates between the instruction-fetch stage and the memory stage, which share one single-ported unified memory with a request/acknowledge handshake. It registers the winning request, holds it on the memory port until acknowledged, and returns read data with a one-cycle done pulse. It drives the per-stage stall lines the pipeline uses to freeze while its access is outstanding. A watchdog guarantees forward progress.

---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter between instruction fetch and the memory stage for one shared single-ported memory.
// Registers the winning request onto the memory port, returns data with a one-cycle done pulse.
module mem_port_arbiter #(
    parameter int unsigned STREAK_MAX = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        err,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic        ram_ack,
    input  logic [31:0] ram_rdata
);

    localparam int unsigned SW = (STREAK_MAX > 0) ? $clog2(STREAK_MAX + 1) : 1;
    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);
    localparam logic [WW-1:0] WD_TOP     = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          ram_req_q, ram_req_d;
    logic          ram_we_q, ram_we_d;
    logic [31:0]   ram_addr_q, ram_addr_d;
    logic [31:0]   ram_wdata_q, ram_wdata_d;
    logic          if_done_q, if_done_d;
    logic          d_done_q, d_done_d;
    logic          err_q, err_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [WW-1:0] wd_q, wd_d;

    logic if_elig, d_elig, grant_if, grant_d;

    // A side being retired this cycle is not eligible, so it cannot be granted twice
    assign if_elig  = if_req && !if_done_q;
    assign d_elig   = d_req && !d_done_q;
    assign grant_d  = (state_q == IDLE) && d_elig && (!if_elig || (streak_q != STREAK_TOP));
    assign grant_if = (state_q == IDLE) && if_elig && !grant_d;

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        streak_d    = streak_q;
        wd_d        = wd_q;

        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    state_d     = BUSY_IF;
                    ram_req_d   = 1'b1;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = if_addr;
                    ram_wdata_d = 32'h0;
                    wd_d        = '0;
                    streak_d    = '0;
                end else if (grant_d) begin
                    state_d     = BUSY_D;
                    ram_req_d   = 1'b1;
                    ram_we_d    = d_we;
                    ram_addr_d  = d_addr;
                    ram_wdata_d = d_wdata;
                    wd_d        = '0;
                    if (!if_elig) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_TOP) begin
                        streak_d = streak_q + SW'(1);
                    end
                end
            end
            BUSY_IF, BUSY_D: begin
                if (ram_ack) begin
                    state_d   = IDLE;
                    ram_req_d = 1'b0;
                    if (state_q == BUSY_IF) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = ram_rdata;
                    end else begin
                        d_done_d = 1'b1;
                        if (!ram_we_q) begin
                            d_rdata_d = ram_rdata;
                        end
                    end
                end else if (wd_q == WD_TOP) begin
                    // Watchdog abort: retire with err and zero data
                    state_d   = IDLE;
                    ram_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == BUSY_IF) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = 32'h0;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = 32'h0;
                    end
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                ram_req_d = 1'b0;
            end
        endcase
    end

    // State and port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 32'h0;
            ram_wdata_q <= 32'h0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
            streak_q    <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            streak_q    <= streak_d;
            wd_q        <= wd_d;
        end
    end

    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign err       = err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req && !if_done_q;
    assign stall_mem = d_req && !d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cycle checks plus a per-side completion scoreboard.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        err;
    logic        stall_if;
    logic        stall_mem;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_ack;
    logic [31:0] ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_if_q[$];
    exp_t exp_d_q[$];
    logic [31:0] d_model;

    logic       ack_en;
    int         ack_lat;
    int         busy_cnt;

    mem_port_arbiter #(.STREAK_MAX(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .err(err),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return (a ^ 32'h5A5A0000) + 32'h11;
    endfunction

    // Memory model: ack after ack_lat cycles of ram_req; data only valid with ack
    always @(posedge clk) begin
        if (rst || !ram_req || ram_ack) busy_cnt <= 0;
        else                            busy_cnt <= busy_cnt + 1;
    end
    assign ram_ack   = ram_req && ack_en && (busy_cnt == ack_lat);
    assign ram_rdata = ram_ack ? mem_rd(ram_addr) : 32'hBAD0BAD0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: pop the per-side expectation on each done pulse
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            if (if_done && d_done) check("both_done", 32'h1, 32'h0);
            if (err && !if_done && !d_done) check("err_orphan", 32'h1, 32'h0);
            if (if_done) begin
                if (exp_if_q.size() == 0) check("if_unexpected_done", 32'h1, 32'h0);
                else begin
                    e = exp_if_q.pop_front();
                    check("if_rdata", if_rdata, e.rdata);
                    check("if_err", 32'(err), 32'(e.err));
                end
            end
            if (d_done) begin
                if (exp_d_q.size() == 0) check("d_unexpected_done", 32'h1, 32'h0);
                else begin
                    e = exp_d_q.pop_front();
                    check("d_rdata", d_rdata, e.rdata);
                    check("d_err", 32'(err), 32'(e.err));
                end
            end
        end
    end

    task automatic push_d_load(input logic [31:0] a);
        d_model = mem_rd(a);
        exp_d_q.push_back('{rdata: d_model, err: 1'b0});
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; ack_en = 1'b1; ack_lat = 0; d_model = 32'h0;
        step(); step();
        check("rst_ram_req", 32'(ram_req), 32'h0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        check("rst_dones", {29'h0, if_done, d_done, err}, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        rst = 1'b0;
        step();

        // IF only, immediate ack
        if_req = 1'b1; if_addr = 32'h40;
        exp_if_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
        #1;
        check("t1_c0_stall_if", 32'(stall_if), 32'h1);
        check("t1_c0_ram_req", 32'(ram_req), 32'h0);
        step();
        check("t1_c1_ram_req", 32'(ram_req), 32'h1);
        check("t1_c1_ram_addr", ram_addr, 32'h40);
        check("t1_c1_ram_we", 32'(ram_we), 32'h0);
        check("t1_c1_stall_if", 32'(stall_if), 32'h1);
        step();
        check("t1_c2_if_done", 32'(if_done), 32'h1);
        check("t1_c2_if_rdata", if_rdata, 32'hDEADBEEF);
        check("t1_c2_ram_req", 32'(ram_req), 32'h0);
        check("t1_c2_stall_if", 32'(stall_if), 32'h0);
        if_req = 1'b0;
        step();
        check("t1_c3_if_done", 32'(if_done), 32'h0);
        check("t1_c3_ram_req", 32'(ram_req), 32'h0);

        // Simultaneous requests: data first, IF granted in the data done cycle
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        push_d_load(32'h100);
        exp_if_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
        #1;
        check("t2_c0_stall_mem", 32'(stall_mem), 32'h1);
        step();
        check("t2_c1_ram_addr", ram_addr, 32'h100);
        step();
        check("t2_c2_d_done", 32'(d_done), 32'h1);
        check("t2_c2_if_done", 32'(if_done), 32'h0);
        check("t2_c2_stall_mem", 32'(stall_mem), 32'h0);
        d_req = 1'b0;
        step();
        check("t2_c3_ram_req", 32'(ram_req), 32'h1);
        check("t2_c3_ram_addr", ram_addr, 32'h40);
        step();
        check("t2_c4_if_done", 32'(if_done), 32'h1);
        if_req = 1'b0;
        step();

        // Store with two wait cycles
        ack_lat = 2;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h12345678;
        exp_d_q.push_back('{rdata: d_model, err: 1'b0});
        for (int k = 1; k <= 3; k++) begin
            step();
            check("t3_ram_req", 32'(ram_req), 32'h1);
            check("t3_ram_we", 32'(ram_we), 32'h1);
            check("t3_ram_addr", ram_addr, 32'h8);
            check("t3_ram_wdata", ram_wdata, 32'h12345678);
        end
        step();
        check("t3_c4_d_done", 32'(d_done), 32'h1);
        check("t3_c4_d_rdata_kept", d_rdata, d_model);
        check("t3_c4_ram_req", 32'(ram_req), 32'h0);
        d_req = 1'b0; d_we = 1'b0;
        step();
        check("t3_c5_d_done", 32'(d_done), 32'h0);
        ack_lat = 0;

        // Watchdog timeout on a load
        ack_en = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        d_model = 32'h0;
        exp_d_q.push_back('{rdata: 32'h0, err: 1'b1});
        for (int k = 1; k <= 16; k++) begin
            step();
            check("t4_ram_req_held", 32'(ram_req), 32'h1);
        end
        step();
        check("t4_c17_ram_req", 32'(ram_req), 32'h0);
        check("t4_c17_d_done", 32'(d_done), 32'h1);
        check("t4_c17_err", 32'(err), 32'h1);
        check("t4_c17_d_rdata", d_rdata, 32'h0);
        d_req = 1'b0;
        ack_en = 1'b1;
        step();
        check("t4_c18_err", 32'(err), 32'h0);

        // Starvation guard: four contested data wins, then IF must win
        for (int r = 0; r < 4; r++) begin
            if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0;
            d_addr = 32'h300 + 32'(r * 4);
            push_d_load(d_addr);
            step();
            check("t5_data_wins", ram_addr, 32'h300 + 32'(r * 4));
            if_req = 1'b0;
            step();
            d_req = 1'b0;
            step();
        end
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_addr = 32'h400;
        exp_if_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
        push_d_load(32'h400);
        step();
        check("t5_if_forced", ram_addr, 32'h40);
        step();
        check("t5_if_done", 32'(if_done), 32'h1);
        if_req = 1'b0;
        step();
        check("t5_d_after_if", ram_addr, 32'h400);
        step();
        d_req = 1'b0;
        step();
        if_req = 1'b1; d_req = 1'b1; d_addr = 32'h500;
        push_d_load(32'h500);
        step();
        check("t5_streak_cleared", ram_addr, 32'h500);
        if_req = 1'b0;
        step();
        d_req = 1'b0;
        step();

        // Reset in the middle of an outstanding fetch
        ack_en = 1'b0;
        if_req = 1'b1; if_addr = 32'h44;
        step();
        check("t6_c1_ram_req", 32'(ram_req), 32'h1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; if_req = 1'b0;
        d_model = 32'h0;
        check("t6_c3_ram_req", 32'(ram_req), 32'h0);
        check("t6_c3_ram_addr", ram_addr, 32'h0);
        check("t6_c3_ram_we_wdata", {ram_wdata[30:0], ram_we}, 32'h0);
        check("t6_c3_flags", {29'h0, if_done, d_done, err}, 32'h0);
        check("t6_c3_if_rdata", if_rdata, 32'h0);
        check("t6_c3_d_rdata", d_rdata, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t6_quiet", {30'h0, ram_req, if_done}, 32'h0);
        end

        // Requester re-presents after reset
        ack_en = 1'b1;
        if_req = 1'b1; if_addr = 32'h40;
        exp_if_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 10; k++) begin
                step();
                if (if_done) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("t6_recover_done", 32'(seen), 32'h1);
        end
        if_req = 1'b0;
        step(); step();

        check("if_queue_empty", 32'(exp_if_q.size()), 32'h0);
        check("d_queue_empty", 32'(exp_d_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
